lemmings_world: RTL and testbench
=================================

Name: lemmings_world

Overview:
- Environment model for the lemmings walker FSM. It tracks one lemming's column and layer in a multi-layer terrain.
- It consumes the FSM's Moore outputs (walk_left, walk_right, aaah, digging) and drives back the FSM's inputs (bump_left, bump_right, ground).
- It closes the loop so the walker can be exercised in-system rather than with hand-timed stimulus. It also exports position and step statistics for checking and display.

Parameters:
- COLS, 16, number of terrain columns per layer; column 0 and COLS-1 are walls.
- XW, 4, width of pos_x; must satisfy 2**XW >= COLS.
- LAYERS, 4, number of terrain layers; layer LAYERS-1 is solid bedrock.
- LW, 2, width of layer output; must satisfy 2**LW >= LAYERS.
- FALL_H, 3, AIR cycles between layers (1..255).
- DIG_CYCLES, 2, consecutive digging cycles needed to open a hole (1..255).
- START_X, 4, column after reset.
- HOLE_INIT, 16'h0400, layer-0 hole map; bit i = 1 means column i is open.

Ports:
- clk  input  1  rising-edge clock.
- resetn  input  1  synchronous active-low reset; sampled on the rising edge of clk.
- walk_left  input  1  from walker FSM.
- walk_right  input  1  from walker FSM.
- aaah  input  1  from walker FSM (falling).
- digging  input  1  from walker FSM.
- bump_left  output  1  to walker FSM.
- bump_right  output  1  to walker FSM.
- ground  output  1  to walker FSM.
- pos_x  output  XW  current column.
- layer  output  LW  current layer.
- steps  output  16  count of completed column moves; saturates at 16'hFFFF.

Behaviour:
- Registers: state {GROUND, AIR}, x, lyr, hole[COLS-1:0], fall_cnt (8b), dig_cnt (8b), steps.
- All outputs decode registered state only; no combinational input-to-output path. This keeps the loop with the Moore walker free of comb loops.
- Reset (resetn=0 at an edge): state=GROUND, x=START_X, lyr=0, hole=HOLE_INIT, fall_cnt=0, dig_cnt=0, steps=0.
  - Outputs after reset: bump_left=0, bump_right=0, ground=~HOLE_INIT[START_X], pos_x=START_X, layer=0, steps=0.
  - Reset overrides everything, including mid-fall and mid-dig.
- Output decode:
  - ground = (state==GROUND) & ~hole[x].
  - bump_left = (state==GROUND) & (x==0).
  - bump_right = (state==GROUND) & (x==COLS-1).
- GROUND, hole[x]=1: next state=AIR, fall_cnt=1, dig_cnt=0, no movement.
- GROUND, hole[x]=0, priority order:
  1. aaah=1: no move, no dig.
  2. digging=1 and lyr!=LAYERS-1: dig_cnt++. When dig_cnt==DIG_CYCLES-1, set hole[x]=1 and clear dig_cnt. The following cycle ground=0.
  3. walk_left XOR walk_right:
     - walk_left=1 and x!=0: x--, steps++.
     - walk_right=1 and x!=COLS-1: x++, steps++.
     - At a wall: no move, no step.
  - digging deasserted before completion clears dig_cnt.
  - digging on bedrock is ignored (dig_cnt stays 0).
  - walk_left and walk_right both high: no move.
- AIR: ground=0, bumps=0, x frozen, walk inputs ignored.
  - fall_cnt<FALL_H: fall_cnt++.
  - fall_cnt==FALL_H: next state=GROUND, lyr++, hole reloaded to all zeros (new layer is solid), fall_cnt=0.
  - Falling from layer LAYERS-2 lands on bedrock; no further increment is possible because bedrock cannot be dug.
- Fall timing: ground stays low for exactly 1+FALL_H consecutive cycles per layer drop (1 GROUND-over-hole cycle plus FALL_H AIR cycles).
- steps saturates and does not wrap.

Test Plan:
- Reset, then release with walk_right=1 held for 6 cycles. Required:
  - Cycle 1: pos_x=4, ground=1.
  - After 6 edges: pos_x=10, ground=0, steps=6.
  - Next cycle: AIR; 1+3 cycles of ground=0; then layer=1, ground=1, pos_x=10.
- On layer 1 (solid), walk_left held until x=0. Required:
  - bump_left=1 exactly when pos_x=0.
  - Further walk_left edges leave pos_x=0 and steps unchanged.
- At x=5 on layer 1, digging=1 for 2 cycles. Required:
  - ground=0 on the 3rd cycle.
  - After 4 more cycles: layer=2.
  - Digging pulse of only 1 cycle, then 0: dig_cnt clears, ground remains 1.
- On layer 3 (bedrock), digging=1 held 10 cycles. Required: ground stays 1, layer stays 3.
- Assert resetn=0 during AIR (fall_cnt=2). Required next cycle: state=GROUND, pos_x=4, layer=0, hole=16'h0400, steps=0, ground=1.
- Closed loop with the walker FSM: after 200 cycles, walk_left and walk_right are never both 1. bump_* is only asserted at columns 0/15. The longest ground=0 run is 4 cycles.

Source files
------------

// File: rtl/lemmings_world.sv
// lemmings_world: terrain/physics model that closes the loop around a
// Moore lemmings walker. Tracks column, layer, per-layer hole map, fall
// and dig progress, and a saturating count of completed column moves.
// Every output decodes registered state only, so wiring it back-to-back
// with a Moore walker cannot form a combinational loop.
module lemmings_world #(
    parameter int                 COLS       = 16,
    parameter int                 XW         = 4,
    parameter int                 LAYERS     = 4,
    parameter int                 LW         = 2,
    parameter int                 FALL_H     = 3,
    parameter int                 DIG_CYCLES = 2,
    parameter int                 START_X    = 4,
    parameter logic [COLS-1:0]    HOLE_INIT  = 16'h0400
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          walk_left,
    input  logic          walk_right,
    input  logic          aaah,
    input  logic          digging,
    output logic          bump_left,
    output logic          bump_right,
    output logic          ground,
    output logic [XW-1:0] pos_x,
    output logic [LW-1:0] layer,
    output logic [15:0]   steps
);

    typedef enum logic {GROUND, AIR} state_t;

    localparam logic [XW-1:0] X_MAX     = XW'(COLS - 1);
    localparam logic [XW-1:0] X_START   = XW'(START_X);
    localparam logic [LW-1:0] L_BED     = LW'(LAYERS - 1);
    localparam logic [7:0]    FALL_LAST = 8'(FALL_H);
    localparam logic [7:0]    DIG_LAST  = 8'(DIG_CYCLES - 1);

    state_t          state_q, state_d;
    logic [XW-1:0]   x_q, x_d;
    logic [LW-1:0]   lyr_q, lyr_d;
    logic [COLS-1:0] hole_q, hole_d;
    logic [7:0]      fall_cnt_q, fall_cnt_d;
    logic [7:0]      dig_cnt_q, dig_cnt_d;
    logic [15:0]     steps_q, steps_d;
    logic            step_en;

    // Next-state physics: fall through holes, dig, walk, land on new layer.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        lyr_d      = lyr_q;
        hole_d     = hole_q;
        fall_cnt_d = fall_cnt_q;
        dig_cnt_d  = dig_cnt_q;
        step_en    = 1'b0;
        case (state_q)
            GROUND: begin
                if (hole_q[x_q]) begin
                    // Standing over an open column: start the drop.
                    state_d    = AIR;
                    fall_cnt_d = 8'd1;
                    dig_cnt_d  = 8'd0;
                end else if (aaah) begin
                    dig_cnt_d = 8'd0;
                end else if (digging && (lyr_q != L_BED)) begin
                    if (dig_cnt_q == DIG_LAST) begin
                        hole_d[x_q] = 1'b1;
                        dig_cnt_d   = 8'd0;
                    end else begin
                        dig_cnt_d = dig_cnt_q + 8'd1;
                    end
                end else begin
                    // Any interruption of digging loses the progress.
                    dig_cnt_d = 8'd0;
                    if (walk_left && !walk_right && (x_q != '0)) begin
                        x_d     = x_q - 1'b1;
                        step_en = 1'b1;
                    end else if (walk_right && !walk_left && (x_q != X_MAX)) begin
                        x_d     = x_q + 1'b1;
                        step_en = 1'b1;
                    end
                end
            end
            AIR: begin
                if (fall_cnt_q == FALL_LAST) begin
                    // Landing: the layer below starts out fully solid.
                    state_d    = GROUND;
                    if (lyr_q != L_BED) lyr_d = lyr_q + 1'b1;
                    hole_d     = '0;
                    fall_cnt_d = 8'd0;
                end else begin
                    fall_cnt_d = fall_cnt_q + 8'd1;
                end
            end
            default: state_d = GROUND;
        endcase
        steps_d = (step_en && (steps_q != 16'hFFFF)) ? steps_q + 16'd1 : steps_q;
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= GROUND;
            x_q        <= X_START;
            lyr_q      <= '0;
            hole_q     <= HOLE_INIT;
            fall_cnt_q <= 8'd0;
            dig_cnt_q  <= 8'd0;
            steps_q    <= 16'd0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            lyr_q      <= lyr_d;
            hole_q     <= hole_d;
            fall_cnt_q <= fall_cnt_d;
            dig_cnt_q  <= dig_cnt_d;
            steps_q    <= steps_d;
        end
    end

    // Registered-state output decode only.
    always_comb begin
        ground     = (state_q == GROUND) && !hole_q[x_q];
        bump_left  = (state_q == GROUND) && (x_q == '0);
        bump_right = (state_q == GROUND) && (x_q == X_MAX);
        pos_x      = x_q;
        layer      = lyr_q;
        steps      = steps_q;
    end

endmodule

// File: tb/tb_lemmings_world.sv
// Bench for lemmings_world: directed vector table, hand sequences for the
// multi-cycle corners, a closed loop with a behavioural walker, and random
// stimulus, all scored against an abstract position/fall/dig model.
module tb_lemmings_world;

    localparam int COLS = 16;
    localparam int FALL_H = 3;
    localparam int DIG_CYCLES = 2;
    localparam int BED = 3;
    localparam int START_X = 4;
    localparam logic [15:0] HOLE0 = 16'h0400;

    logic clk = 1'b0;
    logic resetn, walk_left, walk_right, aaah, digging;
    logic bump_left, bump_right, ground;
    logic [3:0] pos_x;
    logic [1:0] layer;
    logic [15:0] steps;

    int checks = 0;
    int errors = 0;

    lemmings_world dut (
        .clk(clk), .resetn(resetn), .walk_left(walk_left), .walk_right(walk_right),
        .aaah(aaah), .digging(digging), .bump_left(bump_left), .bump_right(bump_right),
        .ground(ground), .pos_x(pos_x), .layer(layer), .steps(steps)
    );

    always #5 clk = ~clk;

    // Abstract world: m_air = AIR cycles still to spend before landing.
    int m_x, m_lyr, m_air, m_dig, m_steps;
    bit m_hole[COLS];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, wl, wr, ah, dg);
        if (!r) begin
            m_x = START_X; m_lyr = 0; m_air = 0; m_dig = 0; m_steps = 0;
            for (int i = 0; i < COLS; i++) m_hole[i] = HOLE0[i];
        end else if (m_air > 0) begin
            m_air--;
            if (m_air == 0) begin
                if (m_lyr < BED) m_lyr++;
                for (int i = 0; i < COLS; i++) m_hole[i] = 1'b0;
            end
        end else if (m_hole[m_x]) begin
            m_air = FALL_H; m_dig = 0;
        end else if (ah) begin
            m_dig = 0;
        end else if (dg && m_lyr != BED) begin
            m_dig++;
            if (m_dig == DIG_CYCLES) begin m_hole[m_x] = 1'b1; m_dig = 0; end
        end else begin
            m_dig = 0;
            if (wl && !wr && m_x > 0) begin
                m_x--; if (m_steps < 65535) m_steps++;
            end else if (wr && !wl && m_x < COLS - 1) begin
                m_x++; if (m_steps < 65535) m_steps++;
            end
        end
    endtask

    task automatic tick(input logic r, wl, wr, ah, dg);
        resetn = r; walk_left = wl; walk_right = wr; aaah = ah; digging = dg;
        @(posedge clk);
        model_step(r, wl, wr, ah, dg);
        #1;
        chk("m.ground", int'(ground), int'(m_air == 0 && !m_hole[m_x]));
        chk("m.bump_left", int'(bump_left), int'(m_air == 0 && m_x == 0));
        chk("m.bump_right", int'(bump_right), int'(m_air == 0 && m_x == COLS - 1));
        chk("m.pos_x", int'(pos_x), m_x);
        chk("m.layer", int'(layer), m_lyr);
        chk("m.steps", int'(steps), m_steps);
    endtask

    typedef struct {
        logic r, wl, wr, ah, dg;
        logic g, bl, br;
        int x, ly, st;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(logic r, wl, wr, ah, dg, g, bl, br, int x, ly, st);
        vec_t v;
        v.r = r; v.wl = wl; v.wr = wr; v.ah = ah; v.dg = dg;
        v.g = g; v.bl = bl; v.br = br; v.x = x; v.ly = ly; v.st = st;
        return v;
    endfunction

    // Walker state for the closed loop.
    bit w_fall, w_dig, w_left;
    int run, max_run;

    initial begin
        resetn = 1'b0; walk_left = 1'b0; walk_right = 1'b0; aaah = 1'b0; digging = 1'b0;

        // Reset, walk right onto the layer-0 hole, fall 1+3 cycles, then walk to the right wall.
        tbl[0] = mk(0,0,0,0,0, 1,0,0, 4,0,0);
        for (int i = 1; i <= 6; i++) tbl[i] = mk(1,0,1,0,0, (i != 6),0,0, 4 + i,0,i);
        tbl[7]  = mk(1,0,0,0,0, 0,0,0, 10,0,6);
        tbl[8]  = mk(1,0,0,0,0, 0,0,0, 10,0,6);
        tbl[9]  = mk(1,0,0,0,0, 0,0,0, 10,0,6);
        tbl[10] = mk(1,0,0,0,0, 1,0,0, 10,1,6);
        for (int i = 11; i <= 15; i++) tbl[i] = mk(1,0,1,0,0, 1,0,(i == 15), i,1,i - 4);
        tbl[16] = mk(1,0,1,0,0, 1,0,1, 15,1,11);
        tbl[17] = mk(1,1,1,0,0, 1,0,1, 15,1,11);

        for (int i = 0; i < 18; i++) begin
            tick(tbl[i].r, tbl[i].wl, tbl[i].wr, tbl[i].ah, tbl[i].dg);
            chk("t.ground", int'(ground), int'(tbl[i].g));
            chk("t.bump_left", int'(bump_left), int'(tbl[i].bl));
            chk("t.bump_right", int'(bump_right), int'(tbl[i].br));
            chk("t.pos_x", int'(pos_x), tbl[i].x);
            chk("t.layer", int'(layer), tbl[i].ly);
            chk("t.steps", int'(steps), tbl[i].st);
        end

        // Walk left into the left wall; bump_left only at column 0.
        for (int i = 0; i < 15; i++) begin
            tick(1, 1, 0, 0, 0);
            chk("wl.bump_left", int'(bump_left), int'(i == 14));
            chk("wl.pos_x", int'(pos_x), 14 - i);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1, 1, 0, 0, 0);
            chk("wall.pos_x", int'(pos_x), 0);
            chk("wall.steps", int'(steps), 26);
        end

        // Go to column 5 and dig through layer 1.
        for (int i = 0; i < 5; i++) tick(1, 0, 1, 0, 0);
        chk("x5", int'(pos_x), 5);
        tick(1, 0, 0, 0, 1);
        chk("dig1.ground", int'(ground), 1);
        tick(1, 0, 0, 0, 1);
        chk("dig2.ground", int'(ground), 0);
        for (int i = 0; i < 4; i++) tick(1, 0, 0, 0, 0);
        chk("dig.layer", int'(layer), 2);
        chk("dig.ground", int'(ground), 1);

        // Single-cycle dig pulse must not open a hole.
        tick(1, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            tick(1, 0, 0, 0, 0);
            chk("pulse.ground", int'(ground), 1);
        end
        tick(1, 0, 0, 0, 1);
        chk("pulse2.ground", int'(ground), 1);
        tick(1, 0, 0, 0, 0);
        chk("pulse2b.ground", int'(ground), 1);

        // Dig down to bedrock, then dig there to no effect.
        tick(1, 0, 0, 0, 1);
        tick(1, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) tick(1, 0, 0, 0, 0);
        chk("bed.layer", int'(layer), 3);
        for (int i = 0; i < 10; i++) begin
            tick(1, 0, 0, 0, 1);
            chk("bed.ground", int'(ground), 1);
            chk("bed.layer_hold", int'(layer), 3);
        end

        // Reset during AIR with fall_cnt=2.
        tick(0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) tick(1, 0, 1, 0, 0);
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        chk("rst.pos_x", int'(pos_x), 4);
        chk("rst.layer", int'(layer), 0);
        chk("rst.steps", int'(steps), 0);
        chk("rst.ground", int'(ground), 1);
        for (int i = 0; i < 6; i++) tick(1, 0, 1, 0, 0);
        chk("rst.hole_restored", int'(ground), 0);

        // Closed loop with a behavioural Moore walker, two runs.
        max_run = 0;
        for (int rep = 0; rep < 2; rep++) begin
            tick(0, 0, 0, 0, 0);
            w_fall = 0; w_dig = 0; w_left = (rep == 1); run = 0;
            for (int c = 0; c < 200; c++) begin
                logic wl, wr, g, bl, br;
                wl = !w_fall && !w_dig && w_left;
                wr = !w_fall && !w_dig && !w_left;
                g = ground; bl = bump_left; br = bump_right;
                tick(1, wl, wr, w_fall, w_dig);
                if (bump_left) chk("loop.bump_left_col", int'(pos_x), 0);
                if (bump_right) chk("loop.bump_right_col", int'(pos_x), COLS - 1);
                if (!ground) run++; else run = 0;
                if (run > max_run) max_run = run;
                if (w_fall) begin
                    if (g) w_fall = 0;
                end else if (w_dig) begin
                    if (!g) begin w_dig = 0; w_fall = 1; end
                    else if ($urandom_range(7) == 0) w_dig = 0;
                end else if (!g) w_fall = 1;
                else if ($urandom_range(9) == 0) w_dig = 1;
                else if (w_left && bl) w_left = 0;
                else if (!w_left && br) w_left = 1;
            end
        end
        checks++;
        if (max_run > 1 + FALL_H || max_run == 0) begin
            errors++;
            $display("FAIL loop.max_ground_low_run: got %0d expected 1..%0d", max_run, 1 + FALL_H);
        end

        // Unconstrained random inputs, occasional reset.
        tick(0, 0, 0, 0, 0);
        for (int c = 0; c < 400; c++) begin
            logic [4:0] rv;
            rv = 5'($urandom);
            tick(($urandom_range(49) != 0), rv[0], rv[1], (rv[4:2] == 3'd0), rv[3] | rv[2]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
